pi_digit_store: RTL and testbench
=================================

Name: pi_digit_store

Overview:
- Writer side of the pi digit memory.
- Accepts raw spigot predigits (0..10) from the pi engine over a valid/ready stream and resolves held-9 / carry corrections into final decimal digits.
- Writes those digits sequentially into internal BCD storage.
- Exposes a 1-cycle-latency indexed read port with the same timing as the existing digit reader, so the display scanner can read from either without change.

Parameters:
DEPTH, 82944, number of digit slots (4 bits each)
IDX_W, 17, width of index/count fields; must satisfy 2**IDX_W >= DEPTH+1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  predigit present
in_ready  out  1  block can accept a predigit this cycle
in_digit  in  4  raw predigit, legal 0..10
in_last  in  1  qualifies final predigit of the stream
rd_index  in  IDX_W  read address
rd_digit  out  4  digit at rd_index, registered
wr_count  out  IDX_W  number of final digits written
full  out  1  sticky: a digit was dropped because wr_count==DEPTH
err  out  1  sticky: illegal predigit or illegal carry seen
done  out  1  stream fully flushed

Behaviour:
- Reset values: in_ready=0 during rst, 1 the cycle after; rd_digit=4'hF; wr_count=0; full=0; err=0; done=0; held predigit pre invalid; nine counter n9=0.
- Memory contents are not cleared by reset; reads are gated by wr_count, so stale data is never visible.
- Handshake: a predigit is accepted when in_valid && in_ready. in_ready=1 only in state ACCEPT.
- States are ACCEPT, EMIT_HEAD, EMIT_RUN, FLUSH_HEAD, FLUSH_RUN, DONE.
- ACCEPT, on accept of q (evaluated in order):
  - q>10: set err, drop q, stay in ACCEPT. in_last with q>10 still goes to FLUSH_HEAD.
  - pre invalid: pre=q, n9=0. If q==10, set err and set pre=0 instead. No write.
  - q==9: n9=n9+1. No write.
  - q==10: head=pre+1, runval=0, go to EMIT_HEAD, then pre=0. If pre==9, set err and use head=0.
  - q<=8: head=pre, runval=9, go to EMIT_HEAD, then pre=q.
  - If in_last is set with an accepted digit, process that digit first as above, then enter FLUSH_HEAD instead of returning to ACCEPT.
- EMIT_HEAD: write head at slot wr_count.
  - If n9>0, go to EMIT_RUN; else go to ACCEPT (or FLUSH_HEAD if last is pending).
- EMIT_RUN: write runval, one digit per cycle, decrementing n9.
  - When n9 reaches 0, go to ACCEPT (or FLUSH_HEAD if last is pending).
- FLUSH_HEAD:
  - If pre is valid, write pre.
  - Then FLUSH_RUN writes n9 nines. Pending nines are final at end of stream.
  - Then go to DONE.
  - If pre is invalid, go directly to DONE.
- DONE: done=1, in_ready=0; hold until rst.
- Write rule: each write stores at slot wr_count and increments wr_count.
  - If wr_count==DEPTH, drop the digit, set full, leave wr_count unchanged.
  - The FSM still advances normally when a digit is dropped.
- Throughput: a predigit causing k writes blocks input for k cycles. A 9, or the first predigit, costs 1 cycle.
- Read port:
  - rd_digit is registered with 1-cycle latency: rd_index sampled at edge t appears at t+1.
  - rd_digit = mem[rd_index] if rd_index < wr_count (value before this cycle's write), else 4'hF.
  - Read and write to the same slot in the same cycle returns 4'hF.
- n9 has width IDX_W and saturates at 2**IDX_W-1; the saturating event sets err.
- Reset mid-emission or mid-flush: all state clears at that edge. The next accepted digit starts a fresh stream at slot 0.

Test Plan:
- Predigits 3,1,4,1,5,9,9,10,2 (last on 2), in_valid held high -> writes 3,1,4,1,6,0,0,0,2. wr_count=9, done=1, err=0. in_ready low exactly 3 cycles after the 10 and 1 cycle after each of 1,4,1,5,2.
- Same stream, then rd_index 0..9 one per cycle -> rd_digit 3,1,4,1,6,0,0,0,2,F, each one cycle after its index.
- DEPTH=4 with predigits 3,1,4,1,5,9 (last on 9) -> slots hold 3,1,4,1. full=1. wr_count=4. Final 5 and 9 dropped. done=1.
- Predigit 11 mid-stream, then 10 as first-ever predigit after reset -> err=1 after each case. The 11 leaves wr_count unchanged. The 10 sets pre=0.
- Reset asserted during EMIT_RUN of a 5-nine run -> next cycle wr_count=0 and in_ready=1. New stream 2,7 (last) writes 2,7 at slots 0,1.
- Read of slot 4 in the same cycle as its write -> 4'hF. Same read on the next cycle -> written digit.

Source files
------------

// File: rtl/pi_digit_store.sv
// rtl/pi_digit_store.sv - resolves spigot predigits (held nines, carries) into final BCD digits
// and stores them sequentially behind a registered, count-gated read port.
module pi_digit_store #(
  parameter int DEPTH = 82944,
  parameter int IDX_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  input  logic [IDX_W-1:0] rd_index,
  output logic [3:0]       rd_digit,
  output logic [IDX_W-1:0] wr_count,
  output logic             full,
  output logic             err,
  output logic             done
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {ACCEPT, EMIT_HEAD, EMIT_RUN, FLUSH_HEAD, FLUSH_RUN, DONE} state_t;

  state_t           state, state_n;
  logic [3:0]       pre, pre_n, head, head_n, runval, runval_n;
  logic             pre_vld, pre_vld_n, last_pend, last_n;
  logic [IDX_W-1:0] n9, n9_n;
  logic             err_set, wr_en, at_cap, accept;
  logic [3:0]       wr_data;
  logic [3:0]       mem [DEPTH];

  assign accept   = in_valid && in_ready;
  assign in_ready = (state == ACCEPT) && !rst;
  assign done     = (state == DONE);
  assign at_cap   = (wr_count == IDX_W'(DEPTH));

  always_comb begin
    state_n   = state;
    pre_n     = pre;
    pre_vld_n = pre_vld;
    n9_n      = n9;
    head_n    = head;
    runval_n  = runval;
    last_n    = last_pend;
    err_set   = 1'b0;
    wr_en     = 1'b0;
    wr_data   = head;
    case (state)
      ACCEPT: begin
        if (accept) begin
          if (in_digit > 4'd10) begin
            err_set = 1'b1;
          end else if (!pre_vld) begin
            pre_vld_n = 1'b1;
            n9_n      = '0;
            if (in_digit == 4'd10) begin
              err_set = 1'b1;
              pre_n   = 4'd0;
            end else begin
              pre_n = in_digit;
            end
          end else if (in_digit == 4'd9) begin
            if (&n9) err_set = 1'b1;
            else     n9_n = n9 + IDX_W'(1);
          end else if (in_digit == 4'd10) begin
            // A carry into a held 9 can only happen on the very first digit; nothing precedes it.
            if (pre == 4'd9) begin
              err_set = 1'b1;
              head_n  = 4'd0;
            end else begin
              head_n = pre + 4'd1;
            end
            runval_n = 4'd0;
            pre_n    = 4'd0;
            state_n  = EMIT_HEAD;
          end else begin
            head_n   = pre;
            runval_n = 4'd9;
            pre_n    = in_digit;
            state_n  = EMIT_HEAD;
          end
          last_n = in_last;
          if (in_last && state_n == ACCEPT) state_n = FLUSH_HEAD;
        end
      end
      EMIT_HEAD: begin
        wr_en   = 1'b1;
        wr_data = head;
        if (n9 != '0)     state_n = EMIT_RUN;
        else if (last_pend) state_n = FLUSH_HEAD;
        else              state_n = ACCEPT;
      end
      EMIT_RUN: begin
        wr_en   = 1'b1;
        wr_data = runval;
        n9_n    = n9 - IDX_W'(1);
        if (n9 == IDX_W'(1)) state_n = last_pend ? FLUSH_HEAD : ACCEPT;
      end
      FLUSH_HEAD: begin
        if (pre_vld) begin
          wr_en   = 1'b1;
          wr_data = pre;
          state_n = (n9 != '0) ? FLUSH_RUN : DONE;
        end else begin
          state_n = DONE;
        end
      end
      FLUSH_RUN: begin
        wr_en   = 1'b1;
        wr_data = 4'd9;
        n9_n    = n9 - IDX_W'(1);
        if (n9 == IDX_W'(1)) state_n = DONE;
      end
      default: state_n = DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCEPT;
      pre       <= 4'd0;
      pre_vld   <= 1'b0;
      n9        <= '0;
      head      <= 4'd0;
      runval    <= 4'd0;
      last_pend <= 1'b0;
      wr_count  <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      pre       <= pre_n;
      pre_vld   <= pre_vld_n;
      n9        <= n9_n;
      head      <= head_n;
      runval    <= runval_n;
      last_pend <= last_n;
      if (err_set) err <= 1'b1;
      if (wr_en) begin
        if (at_cap) full <= 1'b1;
        else        wr_count <= wr_count + IDX_W'(1);
      end
    end
  end

  // Storage is deliberately left uncleared; the read gate on wr_count hides stale slots.
  always_ff @(posedge clk) begin
    if (wr_en && !at_cap) mem[wr_count[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)                    rd_digit <= 4'hF;
    else if (rd_index < wr_count) rd_digit <= mem[rd_index[AW-1:0]];
    else                        rd_digit <= 4'hF;
  end
endmodule

// File: tb/tb_pi_digit_store.sv
// tb/tb_pi_digit_store.sv - directed and randomized checks of pi_digit_store against a digit-queue model
module tb_pi_digit_store;
  localparam int IDX_W = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, sel = 1'b0;
  logic [3:0]       in_digit = 4'd0;
  logic [IDX_W-1:0] rd_index = '0;
  logic             valid_b, valid_s, rdy_b, rdy_s, full_b, full_s, err_b, err_s, done_b, done_s;
  logic [3:0]       rdd_b, rdd_s;
  logic [IDX_W-1:0] wc_b, wc_s;
  logic             rdy, full, err, done;
  logic [3:0]       rdd;
  logic [IDX_W-1:0] wc;

  assign valid_b = in_valid && !sel;
  assign valid_s = in_valid && sel;
  assign rdy  = sel ? rdy_s : rdy_b;
  assign full = sel ? full_s : full_b;
  assign err  = sel ? err_s : err_b;
  assign done = sel ? done_s : done_b;
  assign rdd  = sel ? rdd_s : rdd_b;
  assign wc   = sel ? wc_s : wc_b;

  pi_digit_store dut (
    .clk(clk), .rst(rst), .in_valid(valid_b), .in_ready(rdy_b), .in_digit(in_digit),
    .in_last(in_last), .rd_index(rd_index), .rd_digit(rdd_b), .wr_count(wc_b),
    .full(full_b), .err(err_b), .done(done_b)
  );

  pi_digit_store #(.DEPTH(4), .IDX_W(IDX_W)) dut_small (
    .clk(clk), .rst(rst), .in_valid(valid_s), .in_ready(rdy_s), .in_digit(in_digit),
    .in_last(in_last), .rd_index(rd_index), .rd_digit(rdd_s), .wr_count(wc_s),
    .full(full_s), .err(err_s), .done(done_s)
  );

  int checks = 0, errors = 0;
  logic [3:0] stim_q[$];
  logic [3:0] exp_q[$];
  bit         exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", rdy, 0);
    chk("rst_wr_count", wc, 0);
    chk("rst_rd_digit", rdd, 4'hF);
    chk("rst_flags", {full, err, done}, 0);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", rdy, 1);
  endtask

  task automatic send(input logic [3:0] d, input logic last, output int waited);
    in_digit = d; in_last = last; in_valid = 1'b1; waited = 0;
    while (!rdy && waited < 64) begin @(posedge clk); #1; waited++; end
    chk("accept_ready", rdy, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin @(posedge clk); #1; n++; end
    chk("done", done, 1);
  endtask

  task automatic rd_chk(input int idx, input logic [3:0] exp, input string tag);
    rd_index = IDX_W'(idx);
    @(posedge clk); #1;
    chk(tag, rdd, exp);
  endtask

  // Spigot semantics: every predigit is a tentative digit; a 10 adds one to the digit string so far.
  task automatic run_model();
    exp_q.delete(); exp_err = 0;
    foreach (stim_q[i]) begin
      if (stim_q[i] > 4'd10) begin
        exp_err = 1;
      end else if (stim_q[i] == 4'd10) begin
        if (exp_q.size() == 0) begin
          exp_err = 1;
        end else begin
          int j = exp_q.size() - 1;
          while (j >= 0 && exp_q[j] == 4'd9) begin exp_q[j] = 4'd0; j--; end
          if (j < 0) exp_err = 1;
          else exp_q[j] = exp_q[j] + 4'd1;
        end
        exp_q.push_back(4'd0);
      end else begin
        exp_q.push_back(stim_q[i]);
      end
    end
  endtask

  logic [3:0] d1 [9] = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd9, 4'd10, 4'd2};
  int         w1 [9] = '{0, 0, 1, 1, 1, 1, 0, 0, 3};
  logic [3:0] r1 [10] = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd6, 4'd0, 4'd0, 4'd0, 4'd2, 4'hF};
  logic [3:0] s4 [6] = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9};

  initial begin
    int w;
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(d1[i], i == 8, w);
      chk($sformatf("stall_%0d", i), w, w1[i]);
    end
    wait_done();
    chk("pi_wr_count", wc, 9);
    chk("pi_err", err, 0);
    chk("pi_full", full, 0);
    chk("done_ready_low", rdy, 0);
    for (int i = 0; i < 10; i++) rd_chk(i, r1[i], $sformatf("pi_rd_%0d", i));

    do_reset();
    rd_index = IDX_W'(4);
    for (int i = 0; i < 5; i++) send(d1[i], 1'b0, w);
    send(4'd6, 1'b1, w);
    chk("rw_wc_before", wc, 4);
    @(posedge clk); #1;
    chk("rw_same_cycle", rdd, 4'hF);
    chk("rw_wc_after", wc, 5);
    @(posedge clk); #1;
    chk("rw_next_cycle", rdd, 4'd5);
    wait_done();

    do_reset();
    send(4'd3, 1'b0, w);
    send(4'd1, 1'b0, w);
    send(4'd11, 1'b0, w);
    chk("ill_stall", w, 1);
    chk("ill_err", err, 1);
    chk("ill_wr_count", wc, 1);
    chk("ill_no_block", rdy, 1);
    do_reset();
    send(4'd10, 1'b0, w);
    chk("first10_err", err, 1);
    send(4'd7, 1'b1, w);
    wait_done();
    chk("first10_wc", wc, 2);
    rd_chk(0, 4'd0, "first10_pre0");
    rd_chk(1, 4'd7, "first10_rd1");

    do_reset();
    send(4'd1, 1'b0, w);
    for (int i = 0; i < 5; i++) send(4'd9, 1'b0, w);
    send(4'd4, 1'b0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("run_mid_wc", wc, 2);
    do_reset();
    send(4'd2, 1'b0, w);
    send(4'd7, 1'b1, w);
    wait_done();
    chk("rerun_wc", wc, 2);
    rd_chk(0, 4'd2, "rerun_rd0");
    rd_chk(1, 4'd7, "rerun_rd1");
    rd_chk(2, 4'hF, "rerun_rd2");

    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) send(s4[i], i == 5, w);
    wait_done();
    chk("d4_wc", wc, 4);
    chk("d4_full", full, 1);
    chk("d4_err", err, 0);
    for (int i = 0; i < 4; i++) rd_chk(i, s4[i], $sformatf("d4_rd_%0d", i));
    rd_chk(4, 4'hF, "d4_rd_4");

    for (int r = 0; r < 9; r++) begin
      int len, depth, expwc;
      sel = (r % 3 == 2);
      depth = sel ? 4 : 82944;
      len = $urandom_range(8, 40);
      stim_q.delete();
      for (int i = 0; i < len; i++) begin
        int p = $urandom_range(0, 99);
        if (p < 45)      stim_q.push_back(4'($urandom_range(0, 8)));
        else if (p < 75) stim_q.push_back(4'd9);
        else if (p < 92) stim_q.push_back(4'd10);
        else             stim_q.push_back(4'($urandom_range(11, 15)));
      end
      run_model();
      do_reset();
      foreach (stim_q[i]) send(stim_q[i], i == len - 1, w);
      wait_done();
      expwc = (exp_q.size() > depth) ? depth : exp_q.size();
      chk($sformatf("rnd%0d_wc", r), wc, expwc);
      chk($sformatf("rnd%0d_err", r), err, exp_err);
      chk($sformatf("rnd%0d_full", r), full, exp_q.size() > depth);
      for (int i = 0; i < expwc; i++) rd_chk(i, exp_q[i], $sformatf("rnd%0d_rd_%0d", r, i));
      rd_chk(expwc, 4'hF, $sformatf("rnd%0d_rd_end", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
